// File: rtl/rcc_pkg.sv
// Shared constants and helpers for the ripple-carry toggle-flop counter.
package rcc_pkg;

    localparam int RCC_WIDTH_DEFAULT = 4;
    localparam int RCC_WIDTH_MAX     = 32;

    // Terminal count value (all ones) for a counter of the given width.
    function automatic logic [RCC_WIDTH_MAX-1:0] rcc_all_ones(input int width);
        return {RCC_WIDTH_MAX{1'b1}} >> (RCC_WIDTH_MAX - width);
    endfunction

endpackage

// File: rtl/rcc_tff.sv
// Single toggle flip-flop with synchronous active-low reset.
module rcc_tff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!reset) r_q <= 1'b0;
        else        r_q <= r_q ^ t;
    end

    assign q = r_q;

endmodule

// File: rtl/ripple_carry_counter.sv
// Free-running WIDTH-bit up-counter from a chain of toggle flops and an AND carry chain.
// Define RIPPLE_CARRY_COUNTER_TC_EN to add the terminal-count output tc.
module ripple_carry_counter
    import rcc_pkg::*;
#(
    parameter int WIDTH = RCC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    if (WIDTH < 1 || WIDTH > RCC_WIDTH_MAX) begin : g_width_chk
        $error("ripple_carry_counter: WIDTH %0d outside 1..%0d", WIDTH, RCC_WIDTH_MAX);
    end

    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_q;

    assign w_carry[0] = 1'b1;

    // Bit i toggles only when every lower bit is one.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi > 0) begin : g_chain
            assign w_carry[gi] = w_carry[gi-1] & w_q[gi-1];
        end
        rcc_tff u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (w_carry[gi]),
            .q     (w_q[gi])
        );
    end

    assign q = w_q;

`ifdef RIPPLE_CARRY_COUNTER_TC_EN
    assign tc = w_carry[WIDTH-1] & w_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_ripple_carry_counter.sv
// Scoreboard bench for ripple_carry_counter at WIDTH 4, 1 and 8.
module tb_ripple_carry_counter;

    typedef struct packed {
        logic [3:0] q4;
        logic       q1;
        logic [7:0] q8;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] q4;
    logic       q1;
    logic [7:0] q8;
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
    logic       tc4, tc1, tc8;
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    logic [3:0] m4;
    logic       m1;
    logic [7:0] m8;

    always #5 clk = ~clk;

    ripple_carry_counter #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .q(q4)
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
        , .tc(tc4)
`endif
    );
    ripple_carry_counter #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .q(q1)
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
        , .tc(tc1)
`endif
    );
    ripple_carry_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .q(q8)
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
        , .tc(tc8)
`endif
    );

    // Behavioural model: reset -> 0, else (q+1) mod 2**W; expectation queued per edge.
    always @(posedge clk) begin
        sb.push_back({reset ? m4 + 4'd1 : 4'd0,
                      reset ? ~m1       : 1'b0,
                      reset ? m8 + 8'd1 : 8'd0});
        m4 <= reset ? m4 + 4'd1 : 4'd0;
        m1 <= reset ? ~m1       : 1'b0;
        m8 <= reset ? m8 + 8'd1 : 8'd0;
    end

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q4 !== 4'd0 || q4 !== e.q4) begin
                miscompares++;
                $display("FAIL reset_q4 cyc%0d got %0d want 0", i, q4);
            end
            vectors++;
            if (q1 !== e.q1 || q8 !== e.q8) begin
                miscompares++;
                $display("FAIL reset_w1_w8 cyc%0d got %0d/%0d want %0d/%0d", i, q1, q8, e.q1, e.q8);
            end
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
            vectors++;
            if (tc4 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_tc cyc%0d got %0b want 0", i, tc4);
            end
`endif
        end
        reset = 1'b1;
    endtask

    // One increment per edge from 1 to 15; a short reset glitch between edges is ignored.
    task automatic test_count();
        exp_t e;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q4 !== 4'(i) || q4 !== e.q4) begin
                miscompares++;
                $display("FAIL count_q4 step%0d got %0d want %0d", i, q4, i);
            end
            vectors++;
            if (q1 !== e.q1 || q8 !== e.q8) begin
                miscompares++;
                $display("FAIL count_w1_w8 step%0d got %0d/%0d want %0d/%0d", i, q1, q8, e.q1, e.q8);
            end
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
            vectors++;
            if (tc4 !== (i == 15)) begin
                miscompares++;
                $display("FAIL count_tc step%0d got %0b want %0b", i, tc4, (i == 15));
            end
`endif
            if (i == 2) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q4 !== 4'(i) || q4 !== e.q4) begin
                miscompares++;
                $display("FAIL wrap_q4 cyc%0d got %0d want %0d", i, q4, i);
            end
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
            vectors++;
            if (tc4 !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_tc cyc%0d got %0b want 0", i, tc4);
            end
`endif
        end
        reset = 1'b0;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q4 !== ((i == 2) ? 4'd1 : 4'd0) || q4 !== e.q4) begin
                miscompares++;
                $display("FAIL midreset_q4 cyc%0d got %0d want %0d", i, q4, e.q4);
            end
            vectors++;
            if (q1 !== e.q1 || q8 !== e.q8) begin
                miscompares++;
                $display("FAIL midreset_w1_w8 cyc%0d got %0d/%0d want %0d/%0d", i, q1, q8, e.q1, e.q8);
            end
            if (i == 1) reset = 1'b1;
        end
    endtask

    // Long free run: WIDTH 4 wraps repeatedly, WIDTH 1 toggles, WIDTH 8 passes 255 -> 0.
    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] prev8;
        bit saw_wrap8 = 1'b0;
        prev8 = q8;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q4 !== e.q4 || q1 !== e.q1 || q8 !== e.q8) begin
                miscompares++;
                $display("FAIL run_q cyc%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, q4, q1, q8, e.q4, e.q1, e.q8);
            end
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
            vectors++;
            if (tc4 !== (e.q4 == 4'hF) || tc1 !== e.q1 || tc8 !== (e.q8 == 8'hFF)) begin
                miscompares++;
                $display("FAIL run_tc cyc%0d got %0b/%0b/%0b", i, tc4, tc1, tc8);
            end
`endif
            if (prev8 == 8'hFF && q8 == 8'h00) saw_wrap8 = 1'b1;
            prev8 = q8;
        end
        vectors++;
        if (saw_wrap8 !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap8 got %0b want 1", saw_wrap8);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
